// File: rtl/proc_pkg.sv
// Shared types and widths for the filter processor pipeline control blocks.
package proc_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } state_e;

endpackage

// File: rtl/detector_carga_uso.sv
// Load-use hazard detect: a load in Reg/Exe whose destination is read by the instruction in F/Reg.
module detector_carga_uso
  import proc_pkg::*;
(
  input  logic [REG_W-1:0] ra_i,
  input  logic             re_a_i,
  input  logic [REG_W-1:0] rb_i,
  input  logic             re_b_i,
  input  logic [REG_W-1:0] robj_i,
  input  logic             mem_re_i,
  output logic             load_use_o
);

  logic hit_a, hit_b;

  assign hit_a      = re_a_i & (ra_i == robj_i);
  assign hit_b      = re_b_i & (rb_i == robj_i);
  assign load_use_o = mem_re_i & (hit_a | hit_b);

endmodule

// File: rtl/unidad_detencion.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flushes and memory freezes.
module unidad_detencion
  import proc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Ra_F_Reg,
  input  logic             RE_A_F_Reg,
  input  logic [REG_W-1:0] Rb_F_Reg,
  input  logic             RE_B_F_Reg,
  input  logic [REG_W-1:0] Robj_Reg_Exe,
  input  logic             mem_RE_Reg_Exe,
  input  logic             branch_taken_Exe,
  input  logic             mem_RE_Exe_Mem,
  input  logic             mem_WE_Exe_Mem,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             en_PC,
  output logic             en_F_Reg,
  output logic             en_Reg_Exe,
  output logic             en_Exe_Mem,
  output logic             en_Mem_WB,
  output logic             flush_F_Reg,
  output logic             flush_Reg_Exe,
  output logic             flush_Mem_WB,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [WAIT_W-1:0] TimeoutVal = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WaitOne    = WAIT_W'(1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                pend_q, pend_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic memop, load_use, freeze, advance, timeout;

  assign memop = mem_RE_Exe_Mem | mem_WE_Exe_Mem;

  detector_carga_uso u_detector (
    .ra_i      (Ra_F_Reg),
    .re_a_i    (RE_A_F_Reg),
    .rb_i      (Rb_F_Reg),
    .re_b_i    (RE_B_F_Reg),
    .robj_i    (Robj_Reg_Exe),
    .mem_re_i  (mem_RE_Reg_Exe),
    .load_use_o(load_use)
  );

  // Everything is gated by rst so outputs drop without waiting for a clock edge.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pend_d  = pend_q;
    err_d   = err_q;
    freeze  = 1'b0;
    advance = 1'b0;
    timeout = 1'b0;
    mem_req = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          mem_req = memop;
          if (memop && !mem_ack) begin
            freeze  = 1'b1;
            state_d = StMemWait;
            wait_d  = WaitOne;
          end else begin
            advance = 1'b1;
          end
        end
        StMemWait: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            advance = 1'b1;
            state_d = StRun;
            wait_d  = '0;
          end else if (wait_q == TimeoutVal) begin
            // Abort: the faulting access is dropped and the pipeline moves on.
            mem_req = 1'b0;
            timeout = 1'b1;
            advance = 1'b1;
            err_d   = 1'b1;
            state_d = StRun;
            wait_d  = '0;
          end else begin
            freeze = 1'b1;
            wait_d = wait_q + WaitOne;
          end
        end
        default: state_d = StRun;
      endcase
      if (freeze) begin
        pend_d = pend_q | branch_taken_Exe;
      end else if (advance) begin
        pend_d = 1'b0;
      end
    end
  end

  always_comb begin
    en_PC         = 1'b0;
    en_F_Reg      = 1'b0;
    en_Reg_Exe    = 1'b0;
    en_Exe_Mem    = 1'b0;
    en_Mem_WB     = 1'b0;
    flush_F_Reg   = 1'b0;
    flush_Reg_Exe = 1'b0;
    flush_Mem_WB  = 1'b0;
    if (freeze) begin
      en_Mem_WB    = 1'b1;
      flush_Mem_WB = 1'b1;
    end else if (advance) begin
      en_PC        = 1'b1;
      en_F_Reg     = 1'b1;
      en_Reg_Exe   = 1'b1;
      en_Exe_Mem   = 1'b1;
      en_Mem_WB    = 1'b1;
      flush_Mem_WB = timeout;
      if (pend_q || branch_taken_Exe) begin
        flush_F_Reg   = 1'b1;
        flush_Reg_Exe = 1'b1;
      end else if (load_use) begin
        en_PC         = 1'b0;
        en_F_Reg      = 1'b0;
        flush_Reg_Exe = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!rst && !en_PC && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      wait_q  <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign mem_error   = err_q | timeout;
  assign stall_count = stall_q;

endmodule

// File: doc/unidad_detencion.md
Name: unidad_detencion

Overview:
- Pipeline sequencing controller for the 5-stage filter processor (F, Reg, Exe, Mem, WB).
- Generates per-register enables and flushes.
- Inserts load-use bubbles, flushes wrong-path instructions on taken branches, and freezes the pipeline while the data memory completes a req/ack access.
- Sits beside the forwarding unit: forwarding covers ALU/store hazards, this block covers everything forwarding cannot.

Parameters:
MEM_TIMEOUT, 15, max MEM_WAIT cycles without mem_ack before abort (1..255)
CNT_W, 16, width of stall_count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
Ra_F_Reg  in  4  source A of instruction in F/Reg register
RE_A_F_Reg  in  1  source A is read
Rb_F_Reg  in  4  source B of instruction in F/Reg register
RE_B_F_Reg  in  1  source B is read
Robj_Reg_Exe  in  4  destination of instruction in Reg/Exe
mem_RE_Reg_Exe  in  1  instruction in Reg/Exe is a load
branch_taken_Exe  in  1  branch resolved taken in Exe
mem_RE_Exe_Mem  in  1  load in Mem stage
mem_WE_Exe_Mem  in  1  store in Mem stage
mem_ack  in  1  data memory access complete
mem_req  out  1  data memory access request
en_PC, en_F_Reg, en_Reg_Exe, en_Exe_Mem, en_Mem_WB  out  1 each  register load enables
flush_F_Reg, flush_Reg_Exe, flush_Mem_WB  out  1 each  load a NOP into that register on its next edge
mem_error  out  1  sticky memory timeout flag
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- While rst high: state=RUN, all en_*=0, all flush_*=0, mem_req=0, mem_error=0, stall_count=0, wait counter=0.
- Enables and flushes are combinational from state plus inputs. State, counters and pending-flush flag are registered.
- States: RUN, MEM_WAIT.
- memop = mem_RE_Exe_Mem | mem_WE_Exe_Mem.
- RUN: mem_req = memop.
  - memop & !mem_ack: freeze. All en_*=0 except en_Mem_WB=1 with flush_Mem_WB=1. Go to MEM_WAIT, wait counter=1.
  - memop & mem_ack: zero-wait access, no stall.
- MEM_WAIT: mem_req=1, same freeze outputs.
  - mem_ack: release this cycle. All en_*=1, flush_Mem_WB=0. Go to RUN.
  - No ack and wait counter==MEM_TIMEOUT: drop mem_req, set mem_error, release with flush_Mem_WB=1 (faulting instruction discarded). Go to RUN.
  - Otherwise: wait counter+1.
- Priority in any advancing cycle: memory freeze > taken branch > load-use.
- Taken branch: all enables 1, flush_F_Reg=1, flush_Reg_Exe=1 (two wrong-path instructions killed).
  - Branch asserted during a freeze is latched in pend_branch. The flush is applied on the release cycle, then pend_branch clears.
  - branch_taken_Exe is held stable by upstream while frozen; the latch covers the release edge.
- Load-use: mem_RE_Reg_Exe and (RE_A_F_Reg & Ra_F_Reg==Robj_Reg_Exe or RE_B_F_Reg & Rb_F_Reg==Robj_Reg_Exe).
  - en_PC=0, en_F_Reg=0, flush_Reg_Exe=1, other enables 1.
  - Exactly one bubble. The following cycle the load is in Mem and forwarding supplies the data.
  - Suppressed when a branch flush applies the same cycle.
- Register 0 is not special: matches on 0 stall like any other.
- Normal run: all en_*=1, no flushes.
- stall_count: +1 on each cycle with en_PC=0 (memory freeze or load-use). Saturates at all-ones.
- mem_error clears only on rst. The pipeline keeps running after an error.
- Reset mid-MEM_WAIT: immediate return to RUN, mem_req low asynchronously, pending branch discarded.

Decomposition:
- Shared package (proc_pkg): state enum {RUN, MEM_WAIT}, REG_W=4.
- One sub-module: detector_carga_uso, purely combinational load-use compare (two 4-bit comparators plus enables), reused by the verification scoreboard.
- FSM, wait counter and stall counter stay in the top module.

Test Plan:
- Load-use: LD R3 in Reg/Exe (mem_RE_Reg_Exe=1, Robj=3), next instruction Ra=3 RE_A=1 -> one cycle en_PC=0, en_F_Reg=0, flush_Reg_Exe=1; stall_count 0->1; next cycle all enables 1.
- No false stall: same case with RE_A=0, RE_B=0, Rb=3 -> no stall. Robj=3, Ra=4 -> no stall.
- Memory wait: store in Mem, mem_ack after 3 cycles -> mem_req high 4 cycles, freeze 3 cycles (flush_Mem_WB=1), release on ack cycle; stall_count +3.
- Branch during freeze: branch_taken_Exe=1 in 2nd MEM_WAIT cycle, held until ack -> on release cycle flush_F_Reg=flush_Reg_Exe=1 and all enables 1.
- Timeout: MEM_TIMEOUT=15, mem_ack never -> at 15th wait cycle mem_req=0, mem_error=1, flush_Mem_WB=1, state RUN. Branch and load-use the same cycle -> branch flush only, en_PC=1.
- Async reset asserted mid-MEM_WAIT -> mem_req=0 and enables 0 without a clock edge. After release: RUN, stall_count=0, mem_error=0.
